ip_fetch: RTL and testbench

- Instruction-fetch front end; the initiator that drives line_mem's en/ip pins and consumes the returned line.
- Holds the instruction pointer, issues one fetched line at a time to execute through a valid/ready handshake, and accepts branch/jump redirects from execute.
- Detects the end word (all ones) and parks the CPU in a halted state.

---
 rtl/ip_fetch_pkg.sv | 22 ++
 rtl/ip_fetch.sv | 129 ++++++++++++
 tb/tb_ip_fetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_fetch_pkg.sv
// ip_fetch_pkg: constants and types shared by the instruction-fetch front end.
//   IP_WIDTH   : default width of the instruction pointer
//   LINE_WIDTH : width of one code line
//   OPC_JUMP   : opcode byte (line[31:24]) of an unconditional jump
//   HALT_WORD  : the end-of-program word (all ones)
//   fetch_state_t : IDLE / FETCH / ISSUE / HALT
package ip_fetch_pkg;

   localparam int IP_WIDTH   = 8;
   localparam int LINE_WIDTH = 32;

   localparam logic [7:0]            OPC_JUMP  = 8'h40;
   localparam logic [LINE_WIDTH-1:0] HALT_WORD = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/ip_fetch.sv
// ip_fetch: instruction-fetch front end.
// Holds the instruction pointer, reads one line per fetch from line_mem
// (combinational read), hands it to execute through a valid/ready
// handshake and accepts control-flow redirects. The all-ones word parks
// the unit in HALT until reset.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   run                 : leave IDLE and start fetching
//   mem_en, mem_ip      : read enable / address to line_mem
//   mem_line            : line returned by line_mem in the same cycle
//   line_out, line_ip   : registered instruction and the address it came from
//   line_valid          : line_out holds an unconsumed instruction
//   line_ready          : execute accepts line_out this cycle
//   redirect, redirect_ip : control-flow change requested by execute
//   halted              : end word reached
//
// Build option: define IP_FETCH_JUMP_FOLD_EN to have jumps (opcode 8'h40)
// resolved inside the fetch unit so execute never sees them.
module ip_fetch #(
   parameter int                                     IP_WIDTH   = ip_fetch_pkg::IP_WIDTH,
   parameter int                                     LINE_WIDTH = ip_fetch_pkg::LINE_WIDTH,
   parameter logic [IP_WIDTH-1:0]                    RESET_IP   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   output logic                  mem_en,
   output logic [IP_WIDTH-1:0]   mem_ip,
   input  logic [LINE_WIDTH-1:0] mem_line,
   output logic [LINE_WIDTH-1:0] line_out,
   output logic [IP_WIDTH-1:0]   line_ip,
   output logic                  line_valid,
   input  logic                  line_ready,
   input  logic                  redirect,
   input  logic [IP_WIDTH-1:0]   redirect_ip,
   output logic                  halted
);

   import ip_fetch_pkg::*;

   localparam logic [IP_WIDTH-1:0] IP_ONE = {{(IP_WIDTH-1){1'b0}}, 1'b1};

   fetch_state_t          state_q, state_d;
   logic [IP_WIDTH-1:0]   ip_q, ip_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;
   logic [IP_WIDTH-1:0]   line_ip_q, line_ip_d;
   logic                  valid_q, valid_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ip_q      <= RESET_IP;
         line_q    <= '0;
         line_ip_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ip_q      <= ip_d;
         line_q    <= line_d;
         line_ip_q <= line_ip_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ip_d      = ip_q;
      line_d    = line_q;
      line_ip_d = line_ip_q;
      valid_d   = valid_q;
      case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            // A redirect beats capture: the line being read is from the
            // wrong path, so drop it and refetch at the target.
            if (redirect) begin
               ip_d = redirect_ip;
            end else if (&mem_line) begin
               // End word is latched for visibility but never issued.
               line_d    = mem_line;
               line_ip_d = ip_q;
               state_d   = HALT;
            end
`ifdef IP_FETCH_JUMP_FOLD_EN
            else if (mem_line[31:24] == OPC_JUMP) begin
               ip_d = mem_line[16 +: IP_WIDTH];
            end
`endif
            else begin
               line_d    = mem_line;
               line_ip_d = ip_q;
               valid_d   = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            // Redirect wins whether or not the line is accepted this cycle;
            // without a handshake the held line is simply flushed.
            if (redirect) begin
               ip_d    = redirect_ip;
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (line_ready) begin
               ip_d    = ip_q + IP_ONE;
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         HALT: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   assign mem_en     = (state_q == FETCH);
   assign mem_ip     = ip_q;
   assign line_out   = line_q;
   assign line_ip    = line_ip_q;
   assign line_valid = valid_q;
   assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_ip_fetch.sv
// Self-checking bench for ip_fetch: directed test-plan scenarios followed by
// randomized run/ready/redirect/reset traffic, all checked every cycle
// against a behavioural model of the fetch rules.
module tb_ip_fetch;

   localparam int IPW   = 8;
   localparam int NLINE = 1 << IPW;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             run = 1'b0;
   logic             mem_en;
   logic [IPW-1:0]   mem_ip;
   logic [31:0]      mem_line;
   logic [31:0]      line_out;
   logic [IPW-1:0]   line_ip;
   logic             line_valid;
   logic             line_ready = 1'b0;
   logic             redirect = 1'b0;
   logic [IPW-1:0]   redirect_ip = '0;
   logic             halted;

   logic [31:0] mem [NLINE];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   ip_fetch #(.IP_WIDTH(IPW), .LINE_WIDTH(32), .RESET_IP('0)) dut (
      .clk(clk), .reset(reset), .run(run),
      .mem_en(mem_en), .mem_ip(mem_ip), .mem_line(mem_line),
      .line_out(line_out), .line_ip(line_ip), .line_valid(line_valid),
      .line_ready(line_ready), .redirect(redirect), .redirect_ip(redirect_ip),
      .halted(halted)
   );

   always #5 clk = ~clk;

   // line_mem stand-in: combinational read
   assign mem_line = mem[mem_ip];

`ifdef IP_FETCH_JUMP_FOLD_EN
   localparam bit FOLD = 1'b1;
`else
   localparam bit FOLD = 1'b0;
`endif

   // ---------------- behavioural model ----------------
   // phase: 0 waiting for run, 1 reading memory, 2 offering a line, 3 parked
   int          m_phase = 0;
   int          m_ip = 0;
   logic [31:0] m_line = '0;
   int          m_lip = 0;

   always @(posedge clk) begin
      logic [31:0] w;
      if (reset) begin
         m_phase = 0; m_ip = 0; m_line = '0; m_lip = 0;
      end else if (m_phase == 0) begin
         if (run) m_phase = 1;
      end else if (m_phase == 1) begin
         w = mem[m_ip];
         if (redirect) m_ip = int'(redirect_ip);
         else if (w == 32'hffff_ffff) begin
            m_line = w; m_lip = m_ip; m_phase = 3;
         end else if (FOLD && w[31:24] == 8'h40) m_ip = int'(w[23:16]) % NLINE;
         else begin
            m_line = w; m_lip = m_ip; m_phase = 2;
         end
      end else if (m_phase == 2) begin
         if (redirect) begin
            m_ip = int'(redirect_ip); m_phase = 1;
         end else if (line_ready) begin
            m_ip = (m_ip + 1) % NLINE; m_phase = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (mem_en !== (m_phase == 1) || int'(mem_ip) != m_ip ||
             line_valid !== (m_phase == 2) || halted !== (m_phase == 3) ||
             line_out !== m_line || int'(line_ip) != m_lip) begin
            errors++;
            $display("FAIL model t=%0t act en=%0b ip=%0d v=%0b h=%0b out=%h lip=%0d exp en=%0b ip=%0d v=%0b h=%0b out=%h lip=%0d",
                     $time, mem_en, mem_ip, line_valid, halted, line_out, line_ip,
                     m_phase == 1, m_ip, m_phase == 2, m_phase == 3, m_line, m_lip);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int unsigned acc_q[$];
   bit watch8 = 1'b0;
   bit seen8  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs (called #1 after an edge), then advance.
   task automatic step(input logic r, input logic rdy, input logic rd, input logic [IPW-1:0] rip);
      run = r; line_ready = rdy; redirect = rd; redirect_ip = rip;
      if (watch8 && mem_en && mem_ip == 8'd8) seen8 = 1'b1;
      if (line_valid && rdy && !rd && !reset) acc_q.push_back(int'(line_ip));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      reset = 1'b0;
   endtask

   // Accept lines until the one at target is offered (not yet accepted).
   task automatic wait_ip(input int target);
      for (int i = 0; i < 60; i++) begin
         if (line_valid && int'(line_ip) == target) return;
         step(0, 1, 0, 0);
      end
      errors++;
      $display("FAIL timeout waiting for line_ip=%0d", target);
   endtask

   task automatic wait_any_valid();
      for (int i = 0; i < 60; i++) begin
         if (line_valid) return;
         step(0, 1, 0, 0);
      end
      errors++;
      $display("FAIL timeout waiting for line_valid");
   endtask

   initial begin
      // sum program, then random filler with some end words and jumps
      mem[0] = 32'h03000000; mem[1] = 32'h03010001; mem[2] = 32'h03020600;
      mem[3] = 32'h10000102; mem[4] = 32'h50080102; mem[5] = 32'h20010101;
      mem[6] = 32'h30020201; mem[7] = 32'h40040000; mem[8] = 32'hffffffff;
      for (int i = 9; i < NLINE; i++) begin
         case ($urandom_range(15))
            0:       mem[i] = 32'hffffffff;
            1:       mem[i] = {8'h40, 8'($urandom_range(255)), 16'h0};
            default: mem[i] = {8'h10 + 8'($urandom_range(15)), 24'($urandom)};
         endcase
      end
      mem[255] = 32'h11223344;

      #1;
      do_reset();
      chk_en = 1'b1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_ip", 32'(mem_ip), 32'd0);
      chk("rst_valid",  32'(line_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_line",   line_out, 32'd0);

      // run: line 0 offered two cycles after the run cycle
      step(1, 1, 0, 0);
      chk("lat_cyc1_valid", 32'(line_valid), 32'd0);
      chk("lat_cyc1_mem_en", 32'(mem_en), 32'd1);
      step(0, 1, 0, 0);
      chk("lat_cyc2_valid", 32'(line_valid), 32'd1);
      chk("first_line", line_out, 32'h03000000);
      chk("first_ip", 32'(line_ip), 32'd0);

      // backpressure at ip 2
      wait_ip(2);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0);
         chk("bp_line", line_out, 32'h03020600);
         chk("bp_mem_en", 32'(mem_en), 32'd0);
         chk("bp_mem_ip", 32'(mem_ip), 32'd2);
      end
      step(0, 1, 0, 0);
      chk("bp_rel_mem_en", 32'(mem_en), 32'd1);
      chk("bp_rel_mem_ip", 32'(mem_ip), 32'd3);

      if (!FOLD) begin
         // redirect in the accept cycle of ip 7 -> 4; ip 8 never fetched
         wait_ip(7);
         watch8 = 1'b1;
         step(0, 1, 1, 8'd4);
         wait_any_valid();
         watch8 = 1'b0;
         chk("redir_ip", 32'(line_ip), 32'd4);
         chk("redir_line", line_out, 32'h50080102);
         chk("redir_no_ip8", 32'(seen8), 32'd0);
      end else begin
         // folded jump at 7 is invisible: 6 is followed by 4
         wait_ip(6);
         step(0, 1, 0, 0);
         wait_any_valid();
         chk("fold_ip", 32'(line_ip), 32'd4);
         chk("fold_line", line_out, 32'h50080102);
      end
      checks++;
      if (acc_q.size() < 5 || acc_q[0] != 0 || acc_q[1] != 1 || acc_q[2] != 2 ||
          acc_q[3] != 3 || acc_q[4] != 4) begin
         errors++;
         $display("FAIL accept_seq actual_size=%0d required 0,1,2,3,4", acc_q.size());
      end

      // flush line 5 with redirect to 8 (end word)
      wait_ip(5);
      step(0, 0, 1, 8'd8);
      chk("flush_valid", 32'(line_valid), 32'd0);
      chk("flush_mem_ip", 32'(mem_ip), 32'd8);
      step(0, 1, 0, 0);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_valid", 32'(line_valid), 32'd0);
      chk("halt_mem_en", 32'(mem_en), 32'd0);
      for (int i = 0; i < 4; i++) step(1, 1, 1, 8'd3);
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_sticky_en", 32'(mem_en), 32'd0);

      // wrap: accept at ip 255 -> next fetch at 0
      do_reset();
      step(1, 1, 0, 0);
      wait_ip(0);
      step(0, 1, 1, 8'd255);
      wait_ip(255);
      chk("wrap_line", line_out, 32'h11223344);
      step(0, 1, 0, 0);
      chk("wrap_mem_ip", 32'(mem_ip), 32'd0);
      chk("wrap_mem_en", 32'(mem_en), 32'd1);

      // reset while a line is offered, with competing inputs
      wait_ip(0);
      reset = 1'b1;
      step(1, 1, 1, 8'd5);
      reset = 1'b0;
      chk("mid_rst_valid", 32'(line_valid), 32'd0);
      chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
      chk("mid_rst_mem_ip", 32'(mem_ip), 32'd0);
      chk("mid_rst_line", line_out, 32'd0);
      chk("mid_rst_line_ip", 32'(line_ip), 32'd0);
      chk("mid_rst_halted", 32'(halted), 32'd0);

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(39) == 0);
         step(logic'($urandom_range(1)), logic'($urandom_range(3) != 0),
              logic'($urandom_range(7) == 0), IPW'($urandom_range(NLINE-1)));
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
